// File: rtl/div_arb.sv
// div_arb: round-robin front end that shares one combinational unsigned
// divider among NREQ requesters. Operands are registered on accept, the
// divider is given LAT cycles to settle, and the quotient is returned on a
// single response channel tagged with the requester index.

// div_u: combinational unsigned divider; divide by zero yields all ones.
module div_u #(
  parameter int BWI1 = 8,
  parameter int BWI2 = 8,
  parameter int BWO1 = 8
) (
  input  logic [BWI1-1:0] i_i1,
  input  logic [BWI2-1:0] i_i2,
  output logic [BWO1-1:0] o_q
);
  localparam int BWD = (BWI1 > BWI2) ? BWI1 : BWI2;

  logic [BWD-1:0]  w_qd;
  logic [BWI1-1:0] w_qf;
  logic [BWO1-1:0] w_qx;

  // Divide at the common width; the quotient never exceeds the dividend.
  assign w_qd = BWD'(i_i1) / BWD'(i_i2);
  assign w_qf = w_qd[BWI1-1:0];

  if (BWO1 > BWI1) begin : g_ext
    assign w_qx = {{(BWO1-BWI1){1'b0}}, w_qf};
  end else begin : g_trunc
    assign w_qx = w_qf[BWO1-1:0];
  end

  assign o_q = (i_i2 == '0) ? '1 : w_qx;
endmodule

module div_arb #(
  parameter int BWI1 = 8,
  parameter int BWI2 = 8,
  parameter int BWO1 = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BWI1-1:0] req_i1,
  input  logic [NREQ*BWI2-1:0] req_i2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [BWO1-1:0]      rsp_q,
  output logic                 rsp_dz,
  output logic                 busy
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t          r_state, w_state_next;
  logic [IDW-1:0]  r_ptr, r_id, r_rsp_id;
  logic [CW-1:0]   r_cnt;
  logic [BWI1-1:0] r_op_i1;
  logic [BWI2-1:0] r_op_i2;
  logic            r_rsp_valid, r_rsp_dz;
  logic [BWO1-1:0] r_rsp_q;

  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt_id, w_k;
  logic [NREQ-1:0] w_req_ready;
  logic            w_accept, w_fire, w_done;
  logic [BWO1-1:0] w_div_q;
  logic [BWI1-1:0] w_i1_arr [NREQ];
  logic [BWI2-1:0] w_i2_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_i1_arr[gi] = req_i1[gi*BWI1 +: BWI1];
    assign w_i2_arr[gi] = req_i2[gi*BWI2 +: BWI2];
  end

  div_u #(.BWI1(BWI1), .BWI2(BWI2), .BWO1(BWO1)) u_div (
    .i_i1 (r_op_i1),
    .i_i2 (r_op_i2),
    .o_q  (w_div_q)
  );

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_k         = '0;
    for (int o = 1; o <= NREQ; o++) begin
      w_k = IDW'((int'(r_ptr) + o) % NREQ);
      if (!w_gnt_found && req_valid[w_k]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_k;
      end
    end
  end

  // Next-state logic and handshake strobes; ready only offered in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_fire       = 1'b0;
    w_done       = 1'b0;
    w_req_ready  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_req_ready[w_gnt_id] = 1'b1;
          w_accept              = 1'b1;
          w_state_next          = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == '0) begin
          w_fire       = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Operand capture, settle counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= IDW'(NREQ-1);
      r_id        <= '0;
      r_cnt       <= '0;
      r_op_i1     <= '0;
      r_op_i2     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
      r_rsp_dz    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_i1 <= w_i1_arr[w_gnt_id];
        r_op_i2 <= w_i2_arr[w_gnt_id];
        r_id    <= w_gnt_id;
        r_ptr   <= w_gnt_id;
        r_cnt   <= CW'(LAT-1);
      end else if (r_state == S_CALC && !w_fire) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire) begin
        r_rsp_valid <= 1'b1;
        r_rsp_q     <= w_div_q;
        r_rsp_dz    <= (r_op_i2 == '0);
        r_rsp_id    <= r_id;
      end else if (w_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign rsp_dz    = r_rsp_dz;
  assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_div_arb.sv
// Testbench for div_arb: scoreboard of expected responses filled on each
// accept from a plain-arithmetic reference model, drained by a monitor.
module tb_div_arb;
  localparam int BWI1 = 8, BWI2 = 8, BWO1 = 8, NREQ = 4, IDW = 2, LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_ready4;
  logic [NREQ*BWI1-1:0] req_i1;
  logic [NREQ*BWI2-1:0] req_i2;
  logic                 rsp_valid, rsp_ready, rsp_dz, busy;
  logic [IDW-1:0]       rsp_id;
  logic [BWO1-1:0]      rsp_q;
  logic                 rsp_valid4, rsp_dz4, busy4;
  logic [IDW-1:0]       rsp_id4;
  logic [3:0]           rsp_q4;

  div_arb #(.BWI1(BWI1), .BWI2(BWI2), .BWO1(BWO1), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_i1(req_i1), .req_i2(req_i2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_dz(rsp_dz), .busy(busy));

  // Narrow-quotient build fed in lockstep with the main instance.
  div_arb #(.BWI1(BWI1), .BWI2(BWI2), .BWO1(4), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
    .req_i1(req_i1), .req_i2(req_i2), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id4), .rsp_q(rsp_q4), .rsp_dz(rsp_dz4), .busy(busy4));

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       dz;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   model_last = NREQ - 1;
  int   acc_cnt = 0, last_acc = -1;
  bit   spacing_chk = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
    req_i1[k*8 +: 8] = a;
    req_i2[k*8 +: 8] = b;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || busy || rsp_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", n < budget, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_within_budget", n < budget, 1);
  endtask

  // Accept monitor: reference arbitration and expected quotient.
  always @(negedge clk) begin
    int g, k;
    exp_t e;
    logic [7:0] a, b;
    if (rst_n && (req_valid & req_ready) != '0) begin
      g = -1;
      for (int o = 1; o <= NREQ; o++) begin
        k = (model_last + o) % NREQ;
        if (g < 0 && req_valid[k]) g = k;
      end
      chk("grant", req_ready, 32'(1) << g);
      model_last = g;
      a = req_i1[g*8 +: 8];
      b = req_i2[g*8 +: 8];
      e.id  = g;
      e.q   = (b == 0) ? 8'hFF : a / b;
      e.dz  = (b == 0);
      e.acc = cyc;
      sbq.push_back(e);
      if (spacing_chk && last_acc >= 0) chk("accept_spacing", cyc - last_acc, LAT + 2);
      last_acc = cyc;
      acc_cnt++;
      $display("ACCEPT cyc=%0d id=%0d i1=%0d i2=%0d exp_q=%0d", cyc, g, a, b, e.q);
    end
  end

  // Ready invariants every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot0", $onehot0(req_ready), 1);
      if (busy) chk("ready_low_when_busy", req_ready, 0);
      if (req_valid == '0) chk("ready_low_no_valid", req_ready, 0);
      if (!busy && req_valid != '0) chk("ready_when_idle", req_ready != '0, 1);
    end
  end

  // Response monitor: latency, hold stability and scoreboard compare.
  logic prev_v, prev_r, h_dz;
  logic [IDW-1:0] h_id;
  logic [7:0] h_q;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 0;
      prev_r = 0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("latency", cyc - sbq[0].acc, LAT + 1);
      end
      if (rsp_valid && prev_v && !prev_r) begin
        chk("hold_id", rsp_id, h_id);
        chk("hold_q", rsp_q, h_q);
        chk("hold_dz", rsp_dz, h_dz);
      end
      if (rsp_valid) chk("busy_in_resp", busy, 1);
      if (rsp_valid && rsp_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_q", rsp_q, e.q);
        chk("rsp_dz", rsp_dz, e.dz);
        chk("rsp_valid4", rsp_valid4, 1);
        chk("rsp_q4", rsp_q4, e.q[3:0]);
        chk("rsp_dz4", rsp_dz4, e.dz);
        $display("RSP cyc=%0d id=%0d q=%0d dz=%0d q4=%0h", cyc, rsp_id, rsp_q, rsp_dz, rsp_q4);
      end
      prev_v = rsp_valid;
      prev_r = rsp_ready;
      h_id   = rsp_id;
      h_q    = rsp_q;
      h_dz   = rsp_dz;
    end
  end

  initial begin
    int start;
    rst_n = 0; req_valid = '0; req_i1 = '0; req_i2 = '0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_q", rsp_q, 0);
    chk("reset_rsp_dz", rsp_dz, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;

    // Requester 0 alone: 200/7.
    set_op(0, 8'd200, 8'd7);
    req_valid = 4'b0001; rsp_ready = 1;
    @(negedge clk);
    chk("t1_ready0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(20);

    // All requesters valid continuously, rsp_ready high.
    for (int k = 0; k < NREQ; k++) set_op(k, 8'($urandom), 8'($urandom_range(1, 255)));
    spacing_chk = 1; last_acc = -1; start = acc_cnt;
    req_valid = 4'hF;
    for (int n = 0; n < 40 && acc_cnt < start + 5; n++) @(negedge clk);
    chk("all_valid_accepts", acc_cnt - start >= 5, 1);
    @(posedge clk); #1 req_valid = '0; spacing_chk = 0;
    wait_idle(20);

    // Divide by zero.
    set_op(2, 8'd55, 8'd0);
    req_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(20);

    // Response stalled for 10 cycles with requests pending.
    rsp_ready = 0;
    set_op(1, 8'd99, 8'd5);
    req_valid = 4'hF;
    wait_rsp(20);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_valid", rsp_valid, 1);
    end
    @(posedge clk); #1 rsp_ready = 1; req_valid = '0;
    wait_idle(20);

    // Operands scrambled during CALC must not matter; then 255/1.
    set_op(3, 8'd255, 8'd16);
    req_valid = 4'b1000;
    @(negedge clk);
    for (int n = 0; n < LAT + 1; n++) begin
      @(posedge clk); #1 req_valid = '0;
      req_i1 = $urandom; req_i2 = $urandom;
    end
    wait_idle(20);
    set_op(0, 8'd255, 8'd1);
    req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(20);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      req_i1 = $urandom;
      req_i2 = $urandom;
      for (int k = 0; k < NREQ; k++) if ($urandom_range(0, 7) == 0) req_i2[k*8 +: 8] = 8'd0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = '0; rsp_ready = 1;
    wait_idle(50);

    // Reset pulse during CALC.
    set_op(2, 8'd100, 8'd3);
    req_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    chk("pre_reset_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_q", rsp_q, 0);
    chk("async_rst_id", rsp_id, 0);
    chk("async_rst_dz", rsp_dz, 0);
    sbq.delete();
    model_last = NREQ - 1;
    @(posedge clk); #1 rst_n = 1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1 req_valid = 4'hF;
    @(negedge clk);
    chk("post_reset_grant0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
